// File: rtl/rs_latch_exerciser_if.sv
// Signal bundle between the RS latch exerciser and the latch under test.
// The master side drives S/R and reports status; the slave side returns Q/Qb.
interface rs_latch_exerciser_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             q_in;
    logic             qb_in;
    logic             s_out;
    logic             r_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       step;

    modport master (
        input  start, q_in, qb_in,
        output s_out, r_out, busy, done, pass, mismatch, err_count, step
    );

    modport slave (
        output start, q_in, qb_in,
        input  s_out, r_out, busy, done, pass, mismatch, err_count, step
    );
endinterface

// File: rtl/rs_latch_exerciser.sv
// Drives an RS latch through a fixed 8-step S/R sequence and checks the synchronised
// Q/Qb against an ideal NOR-latch model, reporting mismatches and a final pass flag.
module rs_latch_exerciser #(
    parameter int HOLD_CYCLES = 100,
    parameter int ERR_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rs_latch_exerciser_if.master  bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    if (HOLD_CYCLES < 4) begin : g_hold_check
        $error("rs_latch_exerciser: HOLD_CYCLES must be >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mis_q, mis_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             known_q, known_d;
    logic [1:0]       exp_q, exp_d;
    logic [1:0]       sync_meta_q, sync_q;

    logic             sample;
    logic             fail;
    logic [ERR_W-1:0] err_inc;
    logic [2:0]       model_n;

    function automatic logic [1:0] step_sr(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'b10;
            3'd1:    return 2'b00;
            3'd2:    return 2'b01;
            3'd3:    return 2'b11;
            3'd4:    return 2'b00;
            3'd5:    return 2'b10;
            3'd6:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Returns {known, Q, Qb}; hold after 11 is a race, so the model gives up.
    function automatic logic [2:0] model_next(input logic [1:0] sr_new,
                                              input logic [1:0] sr_prev,
                                              input logic       known,
                                              input logic [1:0] qv);
        case (sr_new)
            2'b10:   return 3'b110;
            2'b01:   return 3'b101;
            2'b11:   return 3'b100;
            default: begin
                if (!known || sr_prev == 2'b11) return 3'b000;
                else                            return {1'b1, qv};
            end
        endcase
    endfunction

    // Two-stage synchroniser for the asynchronous latch outputs; data only, no reset.
    always_ff @(posedge clk) begin
        sync_meta_q <= {bus.q_in, bus.qb_in};
        sync_q      <= sync_meta_q;
    end

    assign sample  = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign fail    = sample && known_q && (sync_q != exp_q);
    assign err_inc = (fail && err_q != ERR_MAX) ? err_q + ERR_W'(1) : err_q;
    assign model_n = model_next(step_sr(step_q + 3'd1), step_sr(step_q), known_q, exp_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        mis_d   = 1'b0;
        err_d   = err_q;
        known_d = known_q;
        exp_d   = exp_q;

        case (state_q)
            RUN: begin
                mis_d = fail;
                err_d = err_inc;
                if (sample) begin
                    cnt_d = '0;
                    if (step_q == 3'd7) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                        s_d     = 1'b0;
                        r_d     = 1'b0;
                    end else begin
                        step_d             = step_q + 3'd1;
                        {s_d, r_d}         = step_sr(step_q + 3'd1);
                        {known_d, exp_d}   = model_n;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (bus.start) begin
                    state_d          = RUN;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    err_d            = '0;
                    step_d           = 3'd0;
                    cnt_d            = '0;
                    {s_d, r_d}       = step_sr(3'd0);
                    {known_d, exp_d} = model_next(step_sr(3'd0), 2'b00, 1'b0, 2'b00);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= '0;
            known_q <= 1'b0;
            exp_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            known_q <= known_d;
            exp_q   <= exp_d;
        end
    end

    assign bus.s_out     = s_q;
    assign bus.r_out     = r_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.mismatch  = mis_q;
    assign bus.err_count = err_q;
    assign bus.step      = step_q;
endmodule

// File: tb/tb_rs_latch_exerciser.sv
// Directed bench: exercises the exerciser against a behavioural NOR latch, a stuck
// latch and a swapped-output latch with a narrow error counter.
module tb_rs_latch_exerciser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mode = 0;  // 0 ideal latch, 1 Q/Qb stuck at 0/1

    logic [1:0] tbl [8] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00};

    always #5 clk = ~clk;

    rs_latch_exerciser_if #(.ERR_W(4)) ifa ();
    rs_latch_exerciser_if #(.ERR_W(2)) ifb ();

    rs_latch_exerciser #(.HOLD_CYCLES(8), .ERR_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    rs_latch_exerciser #(.HOLD_CYCLES(8), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    logic la_q = 1'b0, la_qb = 1'b1;
    logic lb_q = 1'b0, lb_qb = 1'b1;

    always @(ifa.s_out or ifa.r_out) begin
        case ({ifa.s_out, ifa.r_out})
            2'b10:   begin la_q = 1'b1; la_qb = 1'b0; end
            2'b01:   begin la_q = 1'b0; la_qb = 1'b1; end
            2'b11:   begin la_q = 1'b0; la_qb = 1'b0; end
            default: ;
        endcase
    end

    always @(ifb.s_out or ifb.r_out) begin
        case ({ifb.s_out, ifb.r_out})
            2'b10:   begin lb_q = 1'b1; lb_qb = 1'b0; end
            2'b01:   begin lb_q = 1'b0; lb_qb = 1'b1; end
            2'b11:   begin lb_q = 1'b0; lb_qb = 1'b0; end
            default: ;
        endcase
    end

    assign ifa.q_in  = (mode == 1) ? 1'b0 : la_q;
    assign ifa.qb_in = (mode == 1) ? 1'b1 : la_qb;
    assign ifb.q_in  = lb_qb;
    assign ifb.qb_in = lb_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the start edge; walks 64 cycles checking step and S/R, recording
    // which step each mismatch pulse belongs to. Leaves time at start + 64.
    task automatic run_seq(input int start_at, output logic [7:0] mask, output int stray);
        mask  = 8'h00;
        stray = 0;
        for (int j = 0; j < 64; j++) begin
            chk("seq_step", 32'(ifa.step), 32'(j / 8));
            chk("seq_sr", 32'({ifa.s_out, ifa.r_out}), 32'(tbl[j / 8]));
            chk("seq_busy", 32'({ifa.busy, ifa.done}), 32'h2);
            if (ifa.mismatch) begin
                if (j >= 8 && (j % 8) == 0) mask[(j / 8) - 1] = 1'b1;
                else                        stray++;
            end
            ifa.start = (j == start_at);
            tick();
        end
        if (ifa.mismatch) mask[7] = 1'b1;
    endtask

    logic [7:0] mask;
    int         stray;

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) tick();
        chk("rst_a", 32'({ifa.busy, ifa.done, ifa.pass, ifa.mismatch, ifa.err_count,
                          ifa.step, ifa.s_out, ifa.r_out}), 32'h0);
        chk("rst_b", 32'({ifb.busy, ifb.done, ifb.pass, ifb.mismatch, ifb.err_count,
                          ifb.step, ifb.s_out, ifb.r_out}), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_no_busy", 32'({ifa.busy, ifa.done}), 32'h0);

        // Ideal latch run
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("start_busy", 32'(ifa.busy), 32'h1);
        chk("start_err", 32'(ifa.err_count), 32'h0);
        run_seq(-1, mask, stray);
        ifa.start = 1'b0;
        chk("ideal_mask", 32'(mask), 32'h0);
        chk("ideal_stray", 32'(stray), 32'h0);
        chk("ideal_done", 32'({ifa.busy, ifa.done, ifa.pass}), 32'h3);
        chk("ideal_err", 32'(ifa.err_count), 32'h0);
        chk("ideal_end_step", 32'(ifa.step), 32'h7);
        chk("ideal_end_sr", 32'({ifa.s_out, ifa.r_out}), 32'h0);
        tick();
        chk("done_hold", 32'({ifa.busy, ifa.done, ifa.pass}), 32'h3);

        // Stuck latch, started from DONE, with an ignored start at step 2
        mode = 1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("restart_flags", 32'({ifa.busy, ifa.done, ifa.pass}), 32'h4);
        chk("restart_step", 32'(ifa.step), 32'h0);
        chk("restart_sr", 32'({ifa.s_out, ifa.r_out}), 32'h2);
        run_seq(17, mask, stray);
        ifa.start = 1'b0;
        chk("stuck_mask", 32'(mask), 32'h2B);
        chk("stuck_stray", 32'(stray), 32'h0);
        chk("stuck_err", 32'(ifa.err_count), 32'h4);
        chk("stuck_done", 32'({ifa.busy, ifa.done, ifa.pass}), 32'h2);

        // Reset mid-run at step 3
        mode = 0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (26) tick();
        chk("pre_rst_step", 32'(ifa.step), 32'h3);
        rst = 1'b1;
        tick();
        chk("midrst_outs", 32'({ifa.busy, ifa.done, ifa.pass, ifa.mismatch, ifa.err_count,
                                ifa.step, ifa.s_out, ifa.r_out}), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst_idle", 32'({ifa.busy, ifa.done}), 32'h0);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("post_rst_start", 32'({ifa.busy, ifa.step, ifa.err_count}), 32'h80);
        run_seq(63, mask, stray);
        ifa.start = 1'b0;
        chk("post_rst_mask", 32'(mask), 32'h0);
        chk("final_start_done", 32'({ifa.busy, ifa.done, ifa.pass}), 32'h3);
        tick();
        chk("final_start_ign", 32'({ifa.busy, ifa.done, ifa.step}), 32'h0F);

        // Swapped latch on the 2-bit counter instance
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("b_start", 32'({ifb.busy, ifb.step}), 32'h8);
        repeat (64) tick();
        chk("b_done", 32'({ifb.busy, ifb.done, ifb.pass}), 32'h2);
        chk("b_err_sat", 32'(ifb.err_count), 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
